moving_avg_filter: RTL and testbench
====================================

MOVING_AVG_FILTER -- requirements
Module: moving_avg_filter

Interface
REQ-001 The block SHALL have parameter NCH, default 3, meaning the number of independent channels (1..8).
REQ-002 The block SHALL have parameter DW, default 2, meaning the per-channel sample width in bits (1..8).
REQ-003 The block SHALL have parameter LOG2_WIN, default 2, meaning log2 of the window depth; WIN = 2^LOG2_WIN (WIN 2..16).
REQ-004 The block SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, meaning in_data holds a new sample set this cycle.
REQ-007 The block SHALL have port in_data, input, NCH*DW, meaning channel k occupies bits [k*DW +: DW], unsigned.
REQ-008 The block SHALL have port clear, input, 1, meaning a synchronous flush of the window, sums and fill count.
REQ-009 The block SHALL have port mode, input, 1, meaning 0 = average output and 1 = raw window-sum output.
REQ-010 The block SHALL have port out_en, input, 1, meaning 0 forces out_data to zero (combinational gate).
REQ-011 The block SHALL have port out_valid, output, 1, meaning out_data reflects a newly accepted sample.
REQ-012 The block SHALL have port out_data, output, NCH*SW with SW = DW+LOG2_WIN, meaning channel k occupies bits [k*SW +: SW].
REQ-013 The block SHALL have port full, output, 1, meaning at least WIN samples have been accepted since reset or clear.

Function
REQ-014 Each channel SHALL keep a WIN-deep history of DW-bit samples and an SW-bit running sum; the sum SHALL never overflow, since max = WIN*(2^DW-1) < 2^SW.
REQ-015 On a clock edge with in_valid=1 and clear=0: each history SHALL shift by one, the newest sample entering and the oldest leaving; sum_next = sum + new - oldest, computed at SW bits.
REQ-016 With in_valid=0 and clear=0, history, sums and fill count SHALL hold.
REQ-017 out_valid SHALL be a registered copy of (in_valid AND NOT clear), so latency is one cycle from sample to updated output.
REQ-018 In mode=0, per-channel output SHALL be sum >> LOG2_WIN (truncating) zero-extended to SW; in mode=1 it SHALL be sum; mode SHALL be combinational on the registered sums.
REQ-019 During warm-up, empty history slots SHALL count as zero; the average SHALL still divide by WIN, with no renormalisation.
REQ-020 A saturating fill counter of LOG2_WIN+1 bits SHALL increment per accepted sample and stop at WIN; full = (count == WIN).
REQ-021 clear=1 SHALL zero history, sums, fill count and out_valid on the next edge, regardless of in_valid; a sample presented with clear is discarded.
REQ-022 out_en=0 SHALL drive out_data to zero without affecting internal state or out_valid.
REQ-023 Channels SHALL be fully independent; no carry or interaction SHALL occur between channel fields.

Reset
REQ-024 rst_n=0 SHALL asynchronously zero all history, sums, the fill counter, out_valid and full; out_data SHALL then read zero in both modes.
REQ-025 Reset asserted mid-stream SHALL discard all accumulated samples; after release the block SHALL behave as freshly warmed-up from empty.
REQ-026 Reset release SHALL be assumed synchronised externally; the first edge after release MAY accept a sample.

Verification
REQ-027 Defaults, out_en=1, mode=1: feed ch0=3,ch1=1,ch2=2 for 4 valid cycles -> sums 3/1/2, 6/2/4, 9/3/6, 12/4/8; full rises with the 4th output; out_valid is one cycle behind in_valid.
REQ-028 Continuing at steady state, feed ch0=0 for 4 cycles -> ch0 sum 9,6,3,0; mode=0 on the 12 state -> ch0 average 3, ch1 1, ch2 2.
REQ-029 Warm-up average: mode=0, a single sample ch0=3 -> ch0 output 0 (3>>2); after two samples of 3 -> 1.
REQ-030 in_valid gaps: alternate valid/idle for 8 cycles -> sums change only on valid cycles; out_valid pulses single cycles.
REQ-031 clear asserted together with in_valid at full -> next cycle sums=0, full=0, out_valid=0; the following sample of ch0=2 gives sum 2.
REQ-032 rst_n pulsed low asynchronously between edges at full -> outputs zero immediately; repeat REQ-027 with identical results; out_en=0 at any time -> out_data=0.

Source files
------------

// File: rtl/moving_avg_filter.sv
// Multi-channel boxcar moving-average filter over a 2^LOG2_WIN sample window.
// Each channel keeps its own history and running sum; output is the sum or the truncated average.
module moving_avg_filter #(
   parameter int NCH      = 3,
   parameter int DW       = 2,
   parameter int LOG2_WIN = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [NCH*DW-1:0]             in_data,
   input  logic                          clear,
   input  logic                          mode,
   input  logic                          out_en,
   output logic                          out_valid,
   output logic [NCH*(DW+LOG2_WIN)-1:0]  out_data,
   output logic                          full
);

   localparam int WIN = 1 << LOG2_WIN;
   localparam int SW  = DW + LOG2_WIN;
   localparam int CW  = LOG2_WIN + 1;
   localparam logic [CW-1:0] WIN_C = CW'(WIN);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   logic [DW-1:0]     hist_r [NCH][WIN];
   logic [SW-1:0]     sum_r  [NCH];
   logic [CW-1:0]     count_r;
   logic              out_valid_r;
   logic              full_r;
   logic [NCH*SW-1:0] out_data_s;

   // Window histories, running sums, fill counter and output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) begin
            sum_r[k] <= '0;
            for (int j = 0; j < WIN; j++) hist_r[k][j] <= '0;
         end
         count_r     <= '0;
         out_valid_r <= 1'b0;
         full_r      <= 1'b0;
      end else if (clear) begin
         for (int k = 0; k < NCH; k++) begin
            sum_r[k] <= '0;
            for (int j = 0; j < WIN; j++) hist_r[k][j] <= '0;
         end
         count_r     <= '0;
         out_valid_r <= 1'b0;
         full_r      <= 1'b0;
      end else if (in_valid) begin
         // Slot 0 is newest, slot WIN-1 is the sample leaving the window.
         for (int k = 0; k < NCH; k++) begin
            sum_r[k] <= sum_r[k] + SW'(in_data[k*DW +: DW]) - SW'(hist_r[k][WIN-1]);
            for (int j = WIN-1; j > 0; j--) hist_r[k][j] <= hist_r[k][j-1];
            hist_r[k][0] <= in_data[k*DW +: DW];
         end
         if (count_r != WIN_C) begin
            count_r <= count_r + ONE_C;
            full_r  <= (count_r == (WIN_C - ONE_C));
         end else begin
            count_r <= count_r;
            full_r  <= 1'b1;
         end
         out_valid_r <= 1'b1;
      end else begin
         out_valid_r <= 1'b0;
      end
   end

   // Output formatting: mode and out_en act combinationally on the registered sums.
   always_comb begin
      out_data_s = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!out_en) begin
            out_data_s[k*SW +: SW] = '0;
         end else if (mode) begin
            out_data_s[k*SW +: SW] = sum_r[k];
         end else begin
            out_data_s[k*SW +: SW] = sum_r[k] >> LOG2_WIN;
         end
      end
   end

   assign out_data  = out_data_s;
   assign out_valid = out_valid_r;
   assign full      = full_r;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Self-checking bench for moving_avg_filter: directed scenarios plus random traffic
// compared against a window-of-samples reference model.
module tb_moving_avg_filter;

   localparam int NCH      = 3;
   localparam int DW       = 2;
   localparam int LOG2_WIN = 2;
   localparam int WIN      = 1 << LOG2_WIN;
   localparam int SW       = DW + LOG2_WIN;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic [NCH*DW-1:0]   in_data;
   logic                clear;
   logic                mode;
   logic                out_en;
   logic                out_valid;
   logic [NCH*SW-1:0]   out_data;
   logic                full;

   int n_cmp;
   int n_err;

   // Reference state: last WIN samples per channel (index 0 newest), accepted count.
   int m_hist [NCH][WIN];
   int m_cnt;
   bit m_ov;

   moving_avg_filter #(.NCH(NCH), .DW(DW), .LOG2_WIN(LOG2_WIN)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .clear(clear), .mode(mode), .out_en(out_en), .out_valid(out_valid),
      .out_data(out_data), .full(full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NCH; k++)
         for (int i = 0; i < WIN; i++) m_hist[k][i] = 0;
      m_cnt = 0;
      m_ov  = 0;
   endfunction

   function automatic void model_edge(input bit v, input bit c, input logic [NCH*DW-1:0] d);
      if (c) begin
         model_reset();
      end else if (v) begin
         for (int k = 0; k < NCH; k++) begin
            for (int i = WIN-1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
            m_hist[k][0] = int'(d[k*DW +: DW]);
         end
         if (m_cnt < WIN) m_cnt++;
         m_ov = 1;
      end else begin
         m_ov = 0;
      end
   endfunction

   function automatic logic [NCH*SW-1:0] exp_out(input bit m, input bit en);
      logic [NCH*SW-1:0] r;
      r = '0;
      for (int k = 0; k < NCH; k++) begin
         int s;
         s = 0;
         for (int i = 0; i < WIN; i++) s += m_hist[k][i];
         if (en) r[k*SW +: SW] = m ? SW'(s) : SW'(s / WIN);
      end
      return r;
   endfunction

   function automatic logic [NCH*DW-1:0] pack3(input int c0, input int c1, input int c2);
      logic [NCH*DW-1:0] d;
      d = '0;
      d[0*DW +: DW] = DW'(c0);
      d[1*DW +: DW] = DW'(c1);
      d[2*DW +: DW] = DW'(c2);
      return d;
   endfunction

   task automatic check_all(input string tag, input bit m, input bit en);
      mode   = m;
      out_en = en;
      #1;
      check_eq({tag, "_ov"},   64'(out_valid), 64'(m_ov));
      check_eq({tag, "_full"}, 64'(full),      64'(m_cnt == WIN));
      check_eq({tag, "_data"}, 64'(out_data),  64'(exp_out(m, en)));
   endtask

   task automatic step(input bit v, input bit c, input logic [NCH*DW-1:0] d,
                       input bit m, input bit en, input string tag);
      in_valid = v;
      clear    = c;
      in_data  = d;
      @(posedge clk);
      model_edge(v, c, d);
      #1;
      check_all(tag, m, en);
   endtask

   task automatic fill_27();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, pack3(3, 1, 2), 1'b1, 1'b1, "fill");
         check_eq("fill_full_edge", 64'(full), 64'(i == 3));
      end
      check_eq("fill_sum12", 64'(out_data), 64'({4'd8, 4'd4, 4'd12}));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      model_reset();
      rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; in_data = '0; mode = 1'b1; out_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all("rst_m1", 1'b1, 1'b1);
      check_all("rst_m0", 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Warm-up to full, then drain channel 0.
      fill_27();
      check_all("avg12", 1'b0, 1'b1);
      check_eq("avg12_const", 64'(out_data), 64'({4'd2, 4'd1, 4'd3}));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, pack3(0, 1, 2), 1'b1, 1'b1, "drain");
      check_eq("drain_ch0", 64'(out_data[3:0]), 64'd0);

      // Idle cycle then output gate.
      step(1'b0, 1'b0, pack3(3, 3, 3), 1'b1, 1'b1, "idle");
      check_all("gate", 1'b1, 1'b0);

      // Clear coincident with valid at full.
      step(1'b1, 1'b1, pack3(3, 3, 3), 1'b1, 1'b1, "clr");
      step(1'b1, 1'b0, pack3(2, 0, 0), 1'b1, 1'b1, "post_clr");
      check_eq("post_clr_ch0", 64'(out_data[3:0]), 64'd2);

      // Valid/idle alternation.
      for (int i = 0; i < 8; i++)
         step(i % 2 == 0, 1'b0, pack3(i % 4, 3, i % 3), 1'b1, 1'b1, "gaps");

      // Async reset between edges while full.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, pack3(3, 2, 1), 1'b1, 1'b1, "refill");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("arst_m1", 1'b1, 1'b1);
      check_all("arst_m0", 1'b0, 1'b1);
      #1;
      rst_n = 1'b1;
      fill_27();

      // Warm-up average from empty.
      step(1'b1, 1'b1, pack3(0, 0, 0), 1'b0, 1'b1, "wclr");
      step(1'b1, 1'b0, pack3(3, 0, 0), 1'b0, 1'b1, "warm1");
      check_eq("warm1_ch0", 64'(out_data[3:0]), 64'd0);
      step(1'b1, 1'b0, pack3(3, 0, 0), 1'b0, 1'b1, "warm2");
      check_eq("warm2_ch0", 64'(out_data[3:0]), 64'd1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
              NCH*DW'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
